// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2-to-matrix keyboard mapper.
// Holds the keymap entry layout {valid, row[2:0], col[2:0]}, the captured event layout,
// FSM state constants, hotkey scancodes and the default 512-entry keymap table that
// the keymap RAM starts out with at configuration.
package kbd_pkg;

  localparam int unsigned KeymapDepth = 512;
  localparam int unsigned MapW        = 7;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } map_entry_t;

  typedef struct packed {
    logic       pressed;
    logic [8:0] code;     // {extended, scancode}
  } kbd_event_t;

  // Latched hotkey states, each 1 while the key is held.
  typedef struct packed {
    logic nmi;
    logic boot;
    logic rst;
    logic bs;
    logic alt;
    logic del;
    logic ctrl;
  } hotkeys_t;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLookup = 2'd1;
  localparam logic [1:0] StApply  = 2'd2;

  localparam logic [8:0] CodeBackspace = 9'h066;
  localparam logic [8:0] CodeAlt       = 9'h011;
  localparam logic [8:0] CodeDelete    = 9'h171;
  localparam logic [8:0] CodeCtrl      = 9'h014;
  localparam logic [8:0] CodeLeft      = 9'h06B;

  // Default keymap; unlisted codes are invalid (no matrix position).
  localparam logic [MapW-1:0] KeymapDefault [KeymapDepth] = '{
    9'h01C: 7'h41,  // A      r0 c1
    9'h01B: 7'h42,  // S      r0 c2
    9'h023: 7'h43,  // D      r0 c3
    9'h02B: 7'h44,  // F      r0 c4
    9'h015: 7'h48,  // Q      r1 c0
    9'h01D: 7'h49,  // W      r1 c1
    9'h024: 7'h4A,  // E      r1 c2
    9'h016: 7'h50,  // 1      r2 c0
    9'h01E: 7'h51,  // 2      r2 c1
    9'h05A: 7'h58,  // Enter  r3 c0
    9'h06B: 7'h63,  // Left   r4 c3 (keypad)
    9'h16B: 7'h63,  // Left   r4 c3 (extended)
    9'h072: 7'h64,  // Down   r4 c4
    9'h014: 7'h70,  // Ctrl   r6 c0
    9'h012: 7'h78,  // LShift r7 c0
    9'h029: 7'h7F,  // Space  r7 c7
    default: 7'h00
  };

  // True when entry e places its key at matrix position (r, c).
  function automatic logic entry_hits(map_entry_t e, int unsigned r, int unsigned c);
    return e.valid && (e.row == 3'(r)) && (e.col == 3'(c));
  endfunction

endpackage

// File: rtl/kbd_keymap_ram.sv
// 512x7 keymap RAM: one synchronous write port and one registered read port.
// A write and a read of the same address in one cycle return the old contents.
// Contents are not reset; they start from the package default table.
//   clk_i            clock
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i     read enable / address, data on rdata_o the following cycle
module kbd_keymap_ram
  import kbd_pkg::*;
(
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [8:0]      waddr_i,
  input  logic [MapW-1:0] wdata_i,
  input  logic            re_i,
  input  logic [8:0]      raddr_i,
  output logic [MapW-1:0] rdata_o
);

  logic [MapW-1:0] mem_q [KeymapDepth] = KeymapDefault;
  logic [MapW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/kbd_matrix_map.sv
// Translates PS/2 key events into a ROWS x COLS key matrix scanned by a host.
// Each ps2_key[10] toggle is one event; it is looked up in a writable keymap and the
// addressed matrix bit follows the pressed flag. Hotkey combinations drive active-low
// nmi/boot/reset requests. One event may wait while another is in flight; further
// events are dropped and flagged on the sticky overflow output.
//   clock, reset_n (sync, active-low), ce   clocking
//   ps2_key        {strobe, pressed, extended, scancode[7:0]}
//   map_we/map_addr/map_data   keymap write port
//   clear_all      release every key and discard events
//   a -> q         row select -> column sense (combinational)
//   nmi/boot/reset active-low requests, overflow sticky event-loss flag
module kbd_matrix_map
  import kbd_pkg::*;
#(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter logic [8:0]  NMI   = 9'h003,
  parameter logic [8:0]  BOOT  = 9'h078,
  parameter logic [8:0]  RESET = 9'h007
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            ce,
  input  logic [10:0]     ps2_key,
  input  logic            map_we,
  input  logic [8:0]      map_addr,
  input  logic [MapW-1:0] map_data,
  input  logic            clear_all,
  input  logic [ROWS-1:0] a,
  output logic [COLS-1:0] q,
  output logic            nmi,
  output logic            boot,
  output logic            reset,
  output logic            overflow
);

  logic [1:0]                      state_q, state_d;
  logic                            tog_q, tog_d;
  kbd_event_t                      ev_q, ev_d;
  kbd_event_t                      pend_q, pend_d;
  logic                            pend_vld_q, pend_vld_d;
  logic                            ovf_q, ovf_d;
  logic [ROWS-1:0][COLS-1:0]       key_q, key_d;
  hotkeys_t                        hot_q, hot_d;
  // Tracks the keymap entry of the left-arrow code so backspace can be overlaid there.
  map_entry_t                      bs_pos_q = map_entry_t'(KeymapDefault[CodeLeft]);
  map_entry_t                      bs_pos_d;

  logic            toggle;
  kbd_event_t      new_ev;
  logic [MapW-1:0] rd_data;
  map_entry_t      rd_entry;
  logic [ROWS-1:0][COLS-1:0] key_eff;

  assign toggle   = ce && (ps2_key[10] != tog_q);
  assign new_ev   = '{pressed: ps2_key[9], code: ps2_key[8:0]};
  assign rd_entry = map_entry_t'(rd_data);

  kbd_keymap_ram u_keymap (
    .clk_i   (clock),
    .we_i    (ce && map_we),
    .waddr_i (map_addr),
    .wdata_i (map_data),
    .re_i    (ce && (state_q == StLookup)),
    .raddr_i (ev_q.code),
    .rdata_o (rd_data)
  );

  // Next state for event sequencing, matrix and hotkey latches.
  always_comb begin
    state_d    = state_q;
    tog_d      = tog_q;
    ev_d       = ev_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovf_d      = ovf_q;
    key_d      = key_q;
    hot_d      = hot_q;

    if (ce) begin
      tog_d = ps2_key[10];
      if (clear_all) begin
        // Also swallows a toggle arriving in this cycle.
        key_d      = '0;
        hot_d      = '0;
        pend_vld_d = 1'b0;
        state_d    = StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (toggle) begin
              ev_d    = new_ev;
              state_d = StLookup;
            end
          end

          StLookup: begin
            state_d = StApply;
            if (toggle) begin
              if (pend_vld_q) begin
                ovf_d = 1'b1;
              end else begin
                pend_d     = new_ev;
                pend_vld_d = 1'b1;
              end
            end
          end

          StApply: begin
            for (int unsigned r = 0; r < ROWS; r++) begin
              for (int unsigned c = 0; c < COLS; c++) begin
                if (entry_hits(rd_entry, r, c)) begin
                  key_d[r][c] = ev_q.pressed;
                end
              end
            end

            // Hotkeys latch from the code itself, whether or not it is mapped.
            if (ev_q.code == NMI)           hot_d.nmi  = ev_q.pressed;
            if (ev_q.code == BOOT)          hot_d.boot = ev_q.pressed;
            if (ev_q.code == RESET)         hot_d.rst  = ev_q.pressed;
            if (ev_q.code == CodeBackspace) hot_d.bs   = ev_q.pressed;
            if (ev_q.code == CodeAlt)       hot_d.alt  = ev_q.pressed;
            if (ev_q.code == CodeDelete)    hot_d.del  = ev_q.pressed;
            if (ev_q.code == CodeCtrl)      hot_d.ctrl = ev_q.pressed;

            if (pend_vld_q) begin
              ev_d       = pend_q;
              pend_vld_d = 1'b0;
              state_d    = StLookup;
              // The slot is still occupied when this toggle is sampled.
              if (toggle) begin
                ovf_d = 1'b1;
              end
            end else if (toggle) begin
              ev_d    = new_ev;
              state_d = StLookup;
            end else begin
              state_d = StIdle;
            end
          end

          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_comb begin
    bs_pos_d = bs_pos_q;
    if (ce && map_we && (map_addr == CodeLeft)) begin
      bs_pos_d = map_entry_t'(map_data);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      tog_q      <= ps2_key[10];
      ev_q       <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      key_q      <= '0;
      hot_q      <= '0;
    end else begin
      state_q    <= state_d;
      tog_q      <= tog_d;
      ev_q       <= ev_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ovf_q      <= ovf_d;
      key_q      <= key_d;
      hot_q      <= hot_d;
    end
  end

  // Mirrors keymap contents, so it survives reset like the RAM does.
  always_ff @(posedge clock) begin
    bs_pos_q <= bs_pos_d;
  end

  // Matrix as seen by the host: held keys plus backspace overlaid on the left-arrow slot.
  always_comb begin
    key_eff = key_q;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (hot_q.bs && entry_hits(bs_pos_q, r, c)) begin
          key_eff[r][c] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    q = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        q[c] = q[c] | (a[r] & key_eff[r][c]);
      end
    end
    // Outputs idle while reset is held, before the registers have cleared.
    if (!reset_n) begin
      q = '0;
    end
  end

  assign nmi      = !(reset_n && hot_q.nmi);
  assign boot     = !(reset_n && (hot_q.boot || (hot_q.ctrl && hot_q.alt && hot_q.bs)));
  assign reset    = !(reset_n && (hot_q.rst || (hot_q.ctrl && hot_q.alt && hot_q.del)));
  assign overflow = reset_n && ovf_q;

endmodule

// File: doc/kbd_matrix_map.md
KBD_MATRIX_MAP -- requirements
Module: kbd_matrix_map

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of matrix rows (address lines), range 1..8.
REQ-002 SHALL have parameter COLS, default 8, number of matrix columns (data lines), range 1..8.
REQ-003 SHALL have parameter NMI, default 9'h003, extended-bit plus scancode asserting nmi.
REQ-004 SHALL have parameter BOOT, default 9'h078, code asserting boot.
REQ-005 SHALL have parameter RESET, default 9'h007, code asserting reset.
REQ-006 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-008 SHALL have port ce  input  1  clock enable; all state changes except reset qualified by ce.
REQ-009 SHALL have port ps2_key  input  11  [10] toggle strobe, [9] pressed, [8] extended (E0), [7:0] scancode.
REQ-010 SHALL have port map_we  input  1  keymap write strobe (ce-qualified).
REQ-011 SHALL have port map_addr  input  9  keymap index {extended, scancode}.
REQ-012 SHALL have port map_data  input  7  {valid, row[2:0], col[2:0]}.
REQ-013 SHALL have port clear_all  input  1  release every key (focus loss).
REQ-014 SHALL have port a  input  ROWS  active-high row select.
REQ-015 SHALL have port q  output  COLS  active-high column sense.
REQ-016 SHALL have ports nmi, boot, reset  output  1 each  active-low requests.
REQ-017 SHALL have port overflow  output  1  sticky event-loss flag.

Function
REQ-018 SHALL detect an event when ps2_key[10] differs from its previous ce-sampled value; capture {[9],[8],[7:0]} in capture cycle C.
REQ-019 SHALL use FSM IDLE->LOOKUP->APPLY->IDLE: C enters LOOKUP, keymap read in C+1, matrix bit written in C+2 (APPLY); q reflects it in C+3.
REQ-020 SHALL hold one pending event when a toggle arrives in LOOKUP/APPLY; APPLY returns to LOOKUP instead of IDLE when pending is set.
REQ-021 SHALL set overflow when a toggle arrives while pending is full; the new event is dropped, overflow stays set until reset.
REQ-022 SHALL ignore map entries with valid=0, or row>=ROWS, or col>=COLS (no matrix change).
REQ-023 SHALL write key[row][col] <= pressed in APPLY; repeated presses (typematic) leave the bit at 1.
REQ-024 SHALL compare the captured 9-bit code against NMI, BOOT, RESET, 9'h066 (backspace), 9'h011 (alt), 9'h171 (delete) in APPLY independent of map validity, latching pressed.
REQ-025 SHALL drive q[c] = OR over r<ROWS of (a[r] AND key[r][c]), combinationally.
REQ-026 SHALL drive nmi = NOT keyNmi; boot = NOT(keyBoot OR (ctrl AND alt AND backspace)); reset = NOT(keyReset OR (ctrl AND alt AND delete)); ctrl = scancode 9'h014 latch.
REQ-027 SHALL also OR backspace into the matrix position mapped from code 9'h06B (left arrow).
REQ-028 SHALL on clear_all (ce) zero all key bits and hotkey latches, and discard in-flight and pending events; clear_all wins over a same-cycle APPLY.
REQ-029 SHALL perform keymap writes in the same cycle as a lookup with the write taking effect for subsequent lookups only (read-old).

Reset
REQ-030 SHALL on reset_n=0 clear all key bits, hotkey latches, pending, overflow, FSM to IDLE, and load previous-toggle from ps2_key[10] so no spurious event follows reset.
REQ-031 SHALL keep keymap contents across reset; initial contents from the default table at configuration.
REQ-032 SHALL hold q=0, nmi=boot=reset=1, overflow=0 during and immediately after reset.

Structure
REQ-033 SHALL place the map_data field layout, the default 512-entry keymap table and hotkey code constants in shared package kbd_pkg.
REQ-034 SHALL implement the keymap as one sub-module kbd_keymap_ram (512x7, one write port, one registered read port).

Verification
REQ-035 Default map, toggle with pressed=1 code 0x1C, a=8'h01 -> q=8'h02 at C+3; release -> q=8'h00.
REQ-036 Write map[0x1C]={1,3,5}, press 0x1C, a=8'h08 -> q=8'h20; a=8'h01 -> q=0.
REQ-037 Three toggles on consecutive ce cycles -> first two applied, third dropped, overflow=1 until reset_n low.
REQ-038 Press 0x14, 0x11, 0x171 -> reset=0; release 0x11 -> reset=1; press 0x078 alone -> boot=0.
REQ-039 ROWS=4 build, map entry row=6 -> press causes no q change for any a.
REQ-040 Hold keys, assert clear_all or reset_n mid-LOOKUP -> q=0, all requests high, next toggle processed normally.
